// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues instruction-memory reads, buffers returned words
// with their PCs, and hands them to decode over a valid/ready handshake.
module instr_fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     im_re,
  output logic [PC_W-1:0]          im_addr,
  input  logic [31:0]              im_rdata,
  output logic [31:0]              instr,
  output logic [PC_W-1:0]          instr_pc,
  output logic [PC_W-1:0]          nxt_pc,
  output logic                     instr_vld,
  input  logic                     instr_rdy,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     hlt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]     q_instr [DEPTH];
  logic [PC_W-1:0] q_pc    [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count_r;
  logic [PC_W-1:0] pc_p0;
  logic [PC_W-1:0] pc_p1;
  logic            vld_p1;
  logic            halted;

  logic            deq;
  logic            hlt_acc;
  logic            redir;
  logic            flush;
  logic            enq;
  logic [CW:0]     occ;

  assign instr_vld = (count_r != '0);
  assign deq       = instr_vld && instr_rdy;
  assign hlt_acc   = hlt && deq;
  // Halt beats redirect; a redirect arriving after halt has no effect.
  assign redir     = redirect && !halted && !hlt_acc;
  assign flush     = hlt_acc || redir;
  assign enq       = vld_p1 && !flush;

  // Credit check counts the outstanding read but ignores a same-cycle dequeue.
  assign occ   = {1'b0, count_r} + (CW+1)'(vld_p1);
  assign im_re = !halted && !redirect && !hlt_acc && (occ < (CW+1)'(DEPTH));

  assign im_addr  = pc_p0;
  assign instr    = q_instr[head];
  assign instr_pc = q_pc[head];
  assign nxt_pc   = instr_pc + 1'b1;
  assign count    = count_r;

  // Stage p0 -> p1: address issue, PC advance and in-flight tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0  <= RESET_PC;
      pc_p1  <= '0;
      vld_p1 <= 1'b0;
      halted <= 1'b0;
    end else begin
      halted <= halted | hlt_acc;
      vld_p1 <= im_re;
      if (im_re) begin
        pc_p1 <= pc_p0;
      end
      if (redir) begin
        pc_p0 <= redirect_pc;
      end else if (im_re) begin
        pc_p0 <= pc_p0 + 1'b1;
      end
    end
  end

  // Stage p1 -> queue: capture returned word at tail, retire head on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      if (enq) begin
        q_instr[tail] <= im_rdata;
        q_pc[tail]    <= pc_p1;
        tail          <= tail + 1'b1;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_r <= CW'(DEPTH));
  a_no_enq_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(enq && (count_r == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random traffic, all checked
// against a queue-based reference model of fetch, return, dequeue, redirect and halt.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        im_re;
  logic [15:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] nxt_pc;
  logic        instr_vld;
  logic        instr_rdy;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        hlt;
  logic [2:0]  count;

  logic        im_re4;
  logic [3:0]  im_addr4;
  logic [31:0] im_rdata4;
  logic [31:0] instr4;
  logic [3:0]  instr_pc4;
  logic [3:0]  nxt_pc4;
  logic        instr_vld4;
  logic [2:0]  count4;

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .im_re(im_re), .im_addr(im_addr), .im_rdata(im_rdata),
    .instr(instr), .instr_pc(instr_pc), .nxt_pc(nxt_pc), .instr_vld(instr_vld),
    .instr_rdy(instr_rdy), .redirect(redirect), .redirect_pc(redirect_pc), .hlt(hlt),
    .count(count)
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(4), .RESET_PC(4'hE)) dut4 (
    .clk(clk), .rst_n(rst_n), .im_re(im_re4), .im_addr(im_addr4), .im_rdata(im_rdata4),
    .instr(instr4), .instr_pc(instr_pc4), .nxt_pc(nxt_pc4), .instr_vld(instr_vld4),
    .instr_rdy(1'b1), .redirect(1'b0), .redirect_pc(4'h0), .hlt(1'b0),
    .count(count4)
  );

  function automatic logic [31:0] word(input logic [15:0] a);
    return 32'h1000_0000 | {16'h0000, a};
  endfunction

  // Memory: one-cycle read latency, garbage when not read
  always @(posedge clk) begin
    im_rdata  <= im_re  ? word(im_addr) : 32'hDEAD_BEEF;
    im_rdata4 <= im_re4 ? word({12'h000, im_addr4}) : 32'hDEAD_BEEF;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_ipc;
  bit          m_halted;
  bit          m_infl;
  logic [15:0] m_q[$];

  int          cyc;
  int          first_vld;
  logic [31:0] first_instr;
  bit          collect4;
  bit          seen_f4;
  logic [3:0]  a4[$];

  task automatic model_reset();
    m_pc     = 16'h0000;
    m_ipc    = 16'h0000;
    m_halted = 1'b0;
    m_infl   = 1'b0;
    m_q.delete();
    cyc       = 0;
    first_vld = -1;
    first_instr = '0;
  endtask

  // Called at a falling edge; leaves at the next falling edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    instr_rdy = 1'b0; redirect = 1'b0; redirect_pc = '0; hlt = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_vld", instr_vld, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_im_addr4", im_addr4, 4'hE);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: apply inputs, compare against the model, advance the model.
  task automatic step(input bit rdy_i, input bit redir_i, input logic [15:0] rpc_i, input bit hlt_i);
    bit m_vld, hacc, m_re, deq;
    logic [15:0] head_pc;
    instr_rdy = rdy_i; redirect = redir_i; redirect_pc = rpc_i; hlt = hlt_i;
    #1;
    cyc++;
    m_vld   = (m_q.size() != 0);
    head_pc = m_vld ? m_q[0] : 16'h0000;
    hacc    = hlt_i && m_vld && rdy_i;
    deq     = m_vld && rdy_i;
    m_re    = !m_halted && !redir_i && !hacc && ((m_q.size() + int'(m_infl)) < DEPTH);
    check("im_re", im_re, m_re);
    check("im_addr", im_addr, m_pc);
    check("instr_vld", instr_vld, m_vld);
    check("count", count, m_q.size());
    if (m_vld) begin
      check("instr_pc", instr_pc, head_pc);
      check("instr", instr, word(head_pc));
      check("nxt_pc", nxt_pc, 16'(head_pc + 16'd1));
    end
    if (instr_vld && first_vld < 0) begin
      first_vld   = cyc;
      first_instr = instr;
    end
    if (collect4) begin
      if (im_re4) a4.push_back(im_addr4);
      if (instr_vld4 && instr_pc4 == 4'hF) begin
        check("pcw4_nxt_pc", nxt_pc4, 4'h0);
        seen_f4 = 1'b1;
      end
    end
    if (hacc) begin
      m_halted = 1'b1;
      m_q.delete();
      m_infl = 1'b0;
    end else if (redir_i && !m_halted) begin
      m_q.delete();
      m_pc   = rpc_i;
      m_infl = 1'b0;
    end else begin
      if (deq) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_ipc);
      if (m_re) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 16'd1;
      end
      m_infl = m_re;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_rdy = 1'b0; redirect = 1'b0; redirect_pc = '0; hlt = 1'b0;
    collect4 = 1'b0; seen_f4 = 1'b0;
    repeat (2) @(negedge clk);

    // Streaming from reset, plus narrow-PC wrap on the second instance
    do_reset();
    collect4 = 1'b1;
    repeat (12) step(1, 0, 16'h0, 0);
    collect4 = 1'b0;
    check("first_vld_cycle", first_vld, 3);
    check("first_instr", first_instr, 32'h1000_0000);
    if (a4.size() < 3) check("pcw4_issues", a4.size(), 3);
    else begin
      check("pcw4_addr0", a4[0], 4'hE);
      check("pcw4_addr1", a4[1], 4'hF);
      check("pcw4_addr2", a4[2], 4'h0);
    end
    check("pcw4_seen_f", seen_f4, 1);

    // Back-pressure fills the queue, then drains in order
    do_reset();
    repeat (8) step(0, 0, 16'h0, 0);
    #1;
    check("full_count", count, 4);
    check("full_im_re", im_re, 0);
    @(negedge clk);
    repeat (12) step(1, 0, 16'h0, 0);

    // Redirect with count=3 and one read in flight
    do_reset();
    repeat (4) step(0, 0, 16'h0, 0);
    step(0, 1, 16'h0040, 0);
    check("redir_count", count, 0);
    check("redir_addr", im_addr, 16'h0040);
    repeat (10) step(1, 0, 16'h0, 0);
    step(1, 1, 16'hFFFE, 0);
    repeat (8) step(1, 0, 16'h0, 0);

    // Halt accepted at pc 5; later redirects ignored
    do_reset();
    repeat (30) step(1, 0, 16'h0, (m_q.size() > 0) && (m_q[0] == 16'h0005));
    step(1, 1, 16'h0100, 0);
    repeat (20) step(1, 0, 16'h0, 0);
    #1;
    check("halt_im_re", im_re, 0);
    check("halt_vld", instr_vld, 0);
    @(negedge clk);

    // Halt and redirect together
    do_reset();
    repeat (3) step(1, 0, 16'h0, 0);
    step(1, 1, 16'h0200, 1);
    repeat (6) step(1, 0, 16'h0, 0);
    #1;
    check("hlt_redir_addr", im_addr, 16'h0003);
    @(negedge clk);

    // Random traffic with occasional mid-run resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0,
                ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom),
                $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
